// File: rtl/divider_signed_seq_pkg.sv
// Shared definitions for the sequential signed multiply/divide datapaths:
// FSM state encoding and the two's-complement magnitude/negate helper.
package divider_signed_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Widest operand the helper handles; callers zero-extend in and size-cast out.
  localparam int MAX_W = 64;

  // Low bits of the result are the correct negation for any narrower width.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divider_signed_seq_div_step.sv
// One restoring-division iteration: trial subtract of |Y| from the shifted
// partial remainder, keeping the result only when it does not go negative.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] p,
  input  logic         d_bit,
  input  logic [N-1:0] y_mag,
  output logic [N:0]   p_next,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // Partial remainder stays below |Y| <= 2^(N-1), so shifted < 2^N and trial[N] is the sign.
  assign shifted = {p, d_bit};
  assign trial   = shifted - {1'b0, y_mag};
  assign q_bit   = ~trial[N];
  assign p_next  = trial[N] ? shifted : trial;

endmodule

// File: rtl/divider_signed_seq.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Sign-magnitude at load, unsigned iteration, sign fix-up in FIX.
module divider_signed_seq
  import divider_signed_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clk,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [N-1:0] Xin,
  input  logic [N-1:0] Yin,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         DivZero,
  output logic         Ovf
);

  localparam int CW = $clog2(N);

  state_t         state_reg, state_next;
  logic [N-1:0]   dvd_reg, y_mag_reg, q_mag_reg, x_reg;
  logic [N:0]     p_reg;
  logic [CW-1:0]  cnt_reg;
  logic           sq_reg, sr_reg, y_zero_reg, ovf_cond_reg;
  logic [N-1:0]   q_out_reg, r_out_reg;
  logic           div_zero_reg, ovf_reg;

  logic [N-1:0]   x_mag, y_mag;
  logic [N-1:0]   q_fix, r_fix;
  logic [N:0]     step_p;
  logic           step_q;

  assign x_mag = N'(cond_negate(MAX_W'(Xin), Xin[N-1]));
  assign y_mag = N'(cond_negate(MAX_W'(Yin), Yin[N-1]));
  assign q_fix = N'(cond_negate(MAX_W'(q_mag_reg), sq_reg));
  assign r_fix = N'(cond_negate(MAX_W'(p_reg), sr_reg));

  div_step #(.N(N)) u_div_step (
    .p      (p_reg[N-1:0]),
    .d_bit  (dvd_reg[N-1]),
    .y_mag  (y_mag_reg),
    .p_next (step_p),
    .q_bit  (step_q)
  );

  always_comb begin
    state_next = state_reg;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_reg)
      IDLE: if (Start) state_next = DIV;
      DIV: begin
        Busy = 1'b1;
        if (cnt_reg == CW'(N - 1)) state_next = FIX;
      end
      FIX: begin
        Busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_reg    <= IDLE;
      dvd_reg      <= '0;
      y_mag_reg    <= '0;
      q_mag_reg    <= '0;
      x_reg        <= '0;
      p_reg        <= '0;
      cnt_reg      <= '0;
      sq_reg       <= 1'b0;
      sr_reg       <= 1'b0;
      y_zero_reg   <= 1'b0;
      ovf_cond_reg <= 1'b0;
      q_out_reg    <= '0;
      r_out_reg    <= '0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            dvd_reg      <= x_mag;
            y_mag_reg    <= y_mag;
            x_reg        <= Xin;
            q_mag_reg    <= '0;
            p_reg        <= '0;
            cnt_reg      <= '0;
            sq_reg       <= Xin[N-1] ^ Yin[N-1];
            sr_reg       <= Xin[N-1];
            y_zero_reg   <= (Yin == '0);
            ovf_cond_reg <= (Xin == {1'b1, {(N-1){1'b0}}}) && (Yin == '1);
            q_out_reg    <= '0;
            r_out_reg    <= '0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
          end
        end
        DIV: begin
          p_reg     <= step_p;
          q_mag_reg <= {q_mag_reg[N-2:0], step_q};
          dvd_reg   <= dvd_reg << 1;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        FIX: begin
          // Divide-by-zero overrides whatever the iteration produced.
          if (y_zero_reg) begin
            q_out_reg    <= '1;
            r_out_reg    <= x_reg;
            div_zero_reg <= 1'b1;
            ovf_reg      <= 1'b0;
          end else begin
            q_out_reg    <= q_fix;
            r_out_reg    <= r_fix;
            div_zero_reg <= 1'b0;
            ovf_reg      <= ovf_cond_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign Q       = q_out_reg;
  assign R       = r_out_reg;
  assign DivZero = div_zero_reg;
  assign Ovf     = ovf_reg;

endmodule

// File: tb/tb_divider_signed_seq.sv
// Directed vectors, multi-cycle corner sequences and a full 4-bit sweep
// against a truncating-division reference model.
module tb_divider_signed_seq;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Resetn = 1'b0;
  logic         Start = 1'b0;
  logic [N-1:0] Xin = '0;
  logic [N-1:0] Yin = '0;
  logic         Busy, Done, DivZero, Ovf;
  logic [N-1:0] Q, R;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [N-1:0] x, y, q, r;
    logic         dz, ov;
  } vec_t;

  vec_t vecs[15];

  divider_signed_seq #(.N(N)) dut (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .Start   (Start),
    .Xin     (Xin),
    .Yin     (Yin),
    .Busy    (Busy),
    .Done    (Done),
    .Q       (Q),
    .R       (R),
    .DivZero (DivZero),
    .Ovf     (Ovf)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic ref_div(input logic [N-1:0] x, input logic [N-1:0] y,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dz, output logic ov);
    int xs, ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    dz = 1'b0;
    ov = 1'b0;
    if (ys == 0) begin
      q  = '1;
      r  = x;
      dz = 1'b1;
    end else if (xs == -(2 ** (N - 1)) && ys == -1) begin
      q  = {1'b1, {(N-1){1'b0}}};
      r  = '0;
      ov = 1'b1;
    end else begin
      q = N'(xs / ys);
      r = N'(xs % ys);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following Done.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit poke,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic dz, output logic ov);
    int lat;
    bit seen;
    Start = 1'b1;
    Xin   = x;
    Yin   = y;
    @(posedge Clk);
    #1 Start = 1'b0;
    check("busy_after_start", 16'(Busy), 16'd1);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (poke && c == 1) begin
        Start = 1'b1;
        Xin   = ~x;
        Yin   = 4'd1;
      end
      @(posedge Clk);
      #1 Start = 1'b0;
      lat++;
      if (Done) seen = 1'b1;
    end
    check("done_latency", 16'(lat), 16'(N + 1));
    q  = Q;
    r  = R;
    dz = DivZero;
    ov = Ovf;
    $display("op x=%h y=%h -> q=%h r=%h divzero=%0b ovf=%0b latency=%0d", x, y, q, r, dz, ov, lat);
    if (poke) begin
      Start = 1'b1;
      Xin   = 4'd7;
      Yin   = 4'd2;
    end
    @(posedge Clk);
    #1 Start = 1'b0;
    check("done_width", 16'(Done), 16'd0);
    check("idle_after_done", 16'(Busy), 16'd0);
  endtask

  initial begin
    logic [N-1:0] q, r, eq, er;
    logic         dz, ov, edz, eov;
    bit           saw_done;

    vecs[0]  = '{4'd7,    4'd2,    4'b0011, 4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0};
    vecs[2]  = '{4'd7,    4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0};
    vecs[3]  = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1};
    vecs[4]  = '{4'd5,    4'd0,    4'b1111, 4'b0101, 1'b1, 1'b0};
    vecs[5]  = '{4'd6,    4'd3,    4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b1000, 4'd1,    4'b1000, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b1000, 4'd2,    4'b1100, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{4'd0,    4'd5,    4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 4'd7,    4'b0000, 4'b1111, 1'b0, 1'b0};
    vecs[10] = '{4'd7,    4'd7,    4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{4'b1001, 4'b1001, 4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[12] = '{4'd3,    4'b1000, 4'b0000, 4'b0011, 1'b0, 1'b0};
    vecs[13] = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[14] = '{4'b1000, 4'd0,    4'b1111, 4'b1000, 1'b1, 1'b0};

    Resetn = 1'b0;
    Start  = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", 16'({Busy, Done, DivZero, Ovf, Q, R}), 16'd0);
    Start  = 1'b0;
    Resetn = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, 1'b0, q, r, dz, ov);
      check($sformatf("vec%0d_q", i), 16'(q), 16'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 16'(r), 16'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), 16'({dz, ov}), 16'({vecs[i].dz, vecs[i].ov}));
    end

    // Start pulses during DIV and during DONE must not disturb 6/3.
    run_op(4'd6, 4'd3, 1'b1, q, r, dz, ov);
    check("restart_ignored_qr", 16'({q, r}), 16'({4'b0010, 4'b0000}));
    check("restart_ignored_flags", 16'({dz, ov}), 16'd0);

    // Reset while results are held must clear them.
    run_op(4'd7, 4'd2, 1'b0, q, r, dz, ov);
    Resetn = 1'b0;
    @(posedge Clk);
    #1 Resetn = 1'b1;
    check("reset_clears_held", 16'({Busy, Done, DivZero, Ovf, Q, R}), 16'd0);

    // Reset mid-division aborts the operation.
    Start = 1'b1;
    Xin   = 4'd7;
    Yin   = 4'd2;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    #1 Resetn = 1'b0;
    @(posedge Clk);
    #1 Resetn = 1'b1;
    check("reset_mid_div", 16'({Busy, Done, DivZero, Ovf, Q, R}), 16'd0);
    saw_done = 1'b0;
    repeat (N + 3) begin
      @(posedge Clk);
      #1 if (Done || Busy) saw_done = 1'b1;
    end
    check("reset_stays_idle", 16'(saw_done), 16'd0);
    run_op(4'd7, 4'd2, 1'b0, q, r, dz, ov);
    check("after_reset_7_2", 16'({q, r, dz, ov}), 16'({4'b0011, 4'b0001, 1'b0, 1'b0}));

    // Exhaustive back-to-back sweep.
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        ref_div(4'(xi), 4'(yi), eq, er, edz, eov);
        run_op(4'(xi), 4'(yi), 1'b0, q, r, dz, ov);
        check($sformatf("sweep_%0d_%0d", xi, yi), 16'({q, r, dz, ov}), 16'({eq, er, edz, eov}));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_signed_seq.md
Name: divider_signed_seq

Overview:
Sequential restoring divider for signed two's-complement operands, one quotient bit per clock. It is the inverse companion of the team's sequential signed shift-add multiplier and shares its datapath style: sign-magnitude conversion at load, an iterative unsigned core, and sign fix-up at the end. It takes an N-bit dividend and an N-bit divisor and returns an N-bit quotient and an N-bit remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
Clk  input  1  clock; all state updates on rising edge
Resetn  input  1  synchronous, active-low reset
Start  input  1  request; sampled only in IDLE
Xin  input  N  signed dividend, sampled on accepted Start edge
Yin  input  N  signed divisor, sampled on accepted Start edge
Busy  output  1  high from the accepted-Start edge until Done deasserts
Done  output  1  one-cycle pulse; Q, R, DivZero, Ovf valid from this cycle
Q  output  N  signed quotient
R  output  N  signed remainder
DivZero  output  1  Yin was 0
Ovf  output  1  quotient not representable (Xin = -2^(N-1), Yin = -1)

Behaviour:
- Reset: Resetn = 0 at a rising edge -> state IDLE; Busy = 0, Done = 0, Q = 0, R = 0, DivZero = 0, Ovf = 0. Takes effect from any state, including mid-division. Start in the same cycle is ignored.
- States: IDLE, DIV, FIX, DONE; 2-bit encoding.
- IDLE: Start = 1 at an edge -> DIV. On that edge:
  - latch |Xin| and |Yin| as N-bit unsigned magnitudes; |-2^(N-1)| = 2^(N-1) fits.
  - latch sign flags sq = Xin[N-1]^Yin[N-1] and sr = Xin[N-1].
  - clear the (N+1)-bit partial remainder P and the iteration counter.
- DIV: exactly N cycles, MSB first. Each edge:
  - T = {P[N-1:0], dividend MSB} - {0, |Y|}.
  - If T >= 0: P <= T and shift quotient bit 1 in.
  - Else: P unchanged apart from the shift, and shift 0 in.
  - Dividend register shifts left.
  - Counter reaches N-1 -> FIX.
- FIX: one cycle.
  - Q <= sq ? -Qmag : Qmag.
  - R <= sr ? -Pmag : Pmag.
  - Flags registered here.
  - Next state DONE.
- DONE: Done = 1 for exactly this cycle; next state IDLE. Q, R and the flags hold until the next accepted Start edge, which clears them to 0.
- Busy = 1 in DIV, FIX and DONE.
- Latency: Start accepted at edge t0 -> Done high in the cycle after edge t0+N+1, giving N+2 cycles total. Latency is fixed; exceptions do not shorten it.
- Start while Busy: ignored, no effect on the operation in flight.
- Start in the DONE cycle: ignored, so the earliest back-to-back Start is the cycle after Done.
- DivZero (Yin = 0): the iteration still runs. Final outputs are forced to Q = all ones, R = Xin, DivZero = 1, Ovf = 0.
- Ovf (Xin = -2^(N-1), Yin = -1): Q = -2^(N-1) (wrapped), R = 0, Ovf = 1.
- All arithmetic is N or N+1 bits; no wider intermediate values.

Decomposition:
- Shared package:
  - state encoding constants IDLE = 2'b00, DIV = 2'b01, FIX = 2'b10, DONE = 2'b11
  - function for two's-complement magnitude/negate, shared with the multiplier
- One natural sub-module: div_step.
  - Combinational trial subtract and quotient-bit select.
  - Inputs: P, next dividend bit, |Y|. Outputs: next P, q_bit.
  - Instantiated once and iterated by the FSM.

Test Plan:
- N=4, Xin=7, Yin=2, Start pulse -> Done 6 cycles later; Q=4'b0011, R=4'b0001, flags 0.
- Xin=-7 (1001), Yin=2 -> Q=-3 (1101), R=-1 (1111). Xin=7, Yin=-2 -> Q=1101, R=0001.
- Xin=-8 (1000), Yin=-1 -> Ovf=1, Q=1000, R=0000. Xin=5, Yin=0 -> DivZero=1, Q=1111, R=0101, same latency.
- Start re-pulsed during DIV with new operands -> ignored; first result (e.g. 6/3 -> Q=0010, R=0000) delivered on schedule.
- Resetn low for one edge during DIV -> all outputs 0, state IDLE next cycle. A new Start then completes 7/2 correctly.
- Exhaustive sweep, all 256 Xin/Yin pairs, back-to-back Starts -> Q, R and flags match a reference model with truncating division; Done pulse width is 1.
